// File: rtl/multi_clk_divider.sv
// N-channel programmable clock divider: per-channel square wave plus toggle strobe, divisor changes deferred to half-period boundaries.
// Optional MULTI_CLK_DIVIDER_SYNC_RESTART_EN adds a `restart` input that phase-aligns all channels.
module multi_clk_divider #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 83,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MULTI_CLK_DIVIDER_SYNC_RESTART_EN
    input  logic              restart,
`endif
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  div_act_q  [NUM_CH];
    logic [CNT_W-1:0]  div_act_d  [NUM_CH];
    logic [CNT_W-1:0]  div_pend_q [NUM_CH];
    logic [CNT_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    always_comb begin
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            div_act_d[i]  = div_act_q[i];
            div_pend_d[i] = div_pend_q[i];

            if (div_act_q[i] == '0) begin
                // Disabled: hold low; a pending divisor starts a fresh half-period.
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_act_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else if (cnt_q[i] == div_act_q[i] - CNT_W'(1)) begin
                cnt_d[i] = '0;
                if (pend_q[i] && (div_pend_q[i] == '0)) begin
                    clk_out_d[i] = 1'b0;
                end else begin
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = 1'b1;
                end
                if (pend_q[i]) begin
                    div_act_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

`ifdef MULTI_CLK_DIVIDER_SYNC_RESTART_EN
            if (restart) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                if (pend_q[i]) begin
                    div_act_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end
`endif

            // A write on this edge lands after any boundary resolution, so it waits for the next one.
            if (wr_en && (wr_ch == CH_W'(i))) begin
                div_pend_d[i] = wr_div;
                pend_d[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_act_q[i]  <= CNT_W'(DEF_DIV);
                div_pend_q[i] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                div_act_q[i]  <= div_act_d[i];
                div_pend_q[i] <= div_pend_d[i];
            end
        end
    end

    assign pending = pend_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule
